// File: rtl/mem_access_unit_if.sv
// Bus bundle for mem_access_unit: CPU request/response channel plus the data-memory port.
// The unit takes the slave modport; the CPU/memory side takes master.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_address, mem_write_data, mem_write, mem_read
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_address, mem_write_data, mem_write, mem_read
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: accepts one CPU request at a time, checks alignment and range, and performs
// byte/halfword/word accesses on a word-wide memory (sub-word stores use read-modify-write).
module mem_access_unit #(
  parameter int unsigned MEMORY_DEPTH = 256
) (
  input logic              clk,
  input logic              reset,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  state_e      r_state, w_state_next;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_word;
  logic        r_error;

  logic        w_error;
  logic [31:0] w_merged;
  logic [31:0] w_load;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_error = 1'b0;
    case (bus.req_size)
      2'b00:   w_error = 1'b0;
      2'b01:   w_error = bus.req_addr[0];
      2'b10:   w_error = (bus.req_addr[1:0] != 2'b00);
      default: w_error = 1'b1;
    endcase
    if ({2'b00, bus.req_addr[31:2]} >= MEMORY_DEPTH) w_error = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_write    <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_error    <= 1'b0;
      r_word     <= '0;
    end else begin
      if (r_state == StIdle && bus.req_valid) begin
        r_write    <= bus.req_write;
        r_size     <= bus.req_size;
        r_unsigned <= bus.req_unsigned;
        r_addr     <= bus.req_addr;
        r_wdata    <= bus.req_wdata;
        r_error    <= w_error;
      end
      if (r_state == StRd) r_word <= bus.mem_read_data;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (bus.req_valid) begin
          if (w_error)                     w_state_next = StResp;
          else if (!bus.req_write)         w_state_next = StRd;
          else if (bus.req_size == 2'b10)  w_state_next = StWr;
          else                             w_state_next = StRd;
        end
      end
      StRd:    w_state_next = r_write ? StWr : StResp;
      StWr:    w_state_next = StResp;
      StResp:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Store merge: replace only the addressed lane of the word captured in RD.
  always_comb begin
    w_merged = r_word;
    case (r_size)
      2'b00: begin
        case (r_addr[1:0])
          2'b00: w_merged[7:0]   = r_wdata[7:0];
          2'b01: w_merged[15:8]  = r_wdata[7:0];
          2'b10: w_merged[23:16] = r_wdata[7:0];
          2'b11: w_merged[31:24] = r_wdata[7:0];
          default: w_merged = r_word;
        endcase
      end
      2'b01: begin
        if (r_addr[1]) w_merged[31:16] = r_wdata[15:0];
        else           w_merged[15:0]  = r_wdata[15:0];
      end
      default: w_merged = r_wdata;
    endcase
  end

  always_comb begin
    case (r_addr[1:0])
      2'b00:   w_byte = r_word[7:0];
      2'b01:   w_byte = r_word[15:8];
      2'b10:   w_byte = r_word[23:16];
      default: w_byte = r_word[31:24];
    endcase
    w_half = r_addr[1] ? r_word[31:16] : r_word[15:0];
    case (r_size)
      2'b00:   w_load = r_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load = r_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = r_word;
    endcase
  end

  always_comb begin
    bus.req_ready      = 1'b0;
    bus.resp_valid     = 1'b0;
    bus.resp_error     = 1'b0;
    bus.resp_rdata     = '0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_address    = '0;
    bus.mem_write_data = '0;
    case (r_state)
      StIdle: bus.req_ready = 1'b1;
      StRd: begin
        bus.mem_read    = 1'b1;
        bus.mem_address = {r_addr[31:2], 2'b00};
      end
      StWr: begin
        bus.mem_write      = 1'b1;
        bus.mem_address    = {r_addr[31:2], 2'b00};
        bus.mem_write_data = w_merged;
      end
      StResp: begin
        bus.resp_valid = 1'b1;
        bus.resp_error = r_error;
        bus.resp_rdata = (r_error || r_write) ? 32'h0 : w_load;
      end
      default: bus.req_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word memory model and bus monitor.
module tb_mem_access_unit;

  logic clk;
  logic reset;
  mem_access_unit_if bus();

  mem_access_unit #(.MEMORY_DEPTH(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [256];
  assign bus.mem_read_data = bus.mem_read ? mem[bus.mem_address[9:2]] : 32'h0;
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_address[9:2]] <= bus.mem_write_data;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;
  int resp_cnt = 0;
  int overlap  = 0;
  int bad_idle = 0;
  logic [31:0] last_wr_data = '0;
  logic [31:0] last_wr_addr = '0;

  always @(negedge clk) begin
    if (bus.mem_read && bus.mem_write) overlap++;
    if (bus.mem_read) rd_cnt++;
    if (bus.mem_write) begin
      wr_cnt++;
      last_wr_data = bus.mem_write_data;
      last_wr_addr = bus.mem_address;
    end
    if (!bus.mem_read && !bus.mem_write && (bus.mem_address != 0 || bus.mem_write_data != 0))
      bad_idle++;
    if (bus.resp_valid) resp_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the unit idle; returns at the negedge after the response pulse.
  task automatic run_req(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat,
                         input logic exp_err, input logic [31:0] exp_rdata, input int exp_rd,
                         input int exp_wr);
    int   lat;
    logic got;
    int   rd0, wr0;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_valid    = 1'b1;
    #1;
    chk({tag, " ready"}, 32'(bus.req_ready), 32'd1);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(posedge clk);
    #1;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'($urandom);
    bus.req_size     = 2'($urandom);
    bus.req_unsigned = 1'($urandom);
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      got = bus.resp_valid;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " error"}, 32'(bus.resp_error), 32'(exp_err));
    chk({tag, " rdata"}, bus.resp_rdata, exp_rdata);
    @(negedge clk);
    chk({tag, " pulse"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, " reads"}, 32'(rd_cnt - rd0), 32'(exp_rd));
    chk({tag, " writes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
  endtask

  initial begin
    int   lat;
    logic got;
    int   resp0;
    reset            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    repeat (2) @(negedge clk);
    chk("rst ready", 32'(bus.req_ready), 32'd1);
    chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst resp_error", 32'(bus.resp_error), 32'd0);
    chk("rst resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst mem_enables", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
    chk("rst mem_address", bus.mem_address, 32'h0);
    chk("rst mem_wdata", bus.mem_write_data, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Word store then load
    run_req("sw 0x10", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 2, 0, 32'h0, 0, 1);
    chk("sw data", last_wr_data, 32'hDEADBEEF);
    chk("sw addr", last_wr_addr, 32'h10);
    run_req("lw 0x10", 0, 2'b10, 1, 32'h10, 32'h0, 2, 0, 32'hDEADBEEF, 1, 0);

    // Byte store into 0x11223344 and sign/zero loads
    run_req("sw init1", 1, 2'b10, 0, 32'h10, 32'h11223344, 2, 0, 32'h0, 0, 1);
    run_req("sb 0x12", 1, 2'b00, 0, 32'h12, 32'h123456AA, 3, 0, 32'h0, 1, 1);
    chk("sb data", last_wr_data, 32'h11AA3344);
    chk("sb addr", last_wr_addr, 32'h10);
    run_req("lb 0x12", 0, 2'b00, 0, 32'h12, 32'h0, 2, 0, 32'hFFFFFFAA, 1, 0);
    run_req("lbu 0x12", 0, 2'b00, 1, 32'h12, 32'h0, 2, 0, 32'h000000AA, 1, 0);
    run_req("lb 0x13", 0, 2'b00, 0, 32'h13, 32'h0, 2, 0, 32'h00000011, 1, 0);

    // Halfword store and loads
    run_req("sw init2", 1, 2'b10, 0, 32'h10, 32'h11223344, 2, 0, 32'h0, 0, 1);
    run_req("sh 0x10", 1, 2'b01, 0, 32'h10, 32'hFFFF8001, 3, 0, 32'h0, 1, 1);
    chk("sh data", last_wr_data, 32'h11228001);
    run_req("lh 0x10", 0, 2'b01, 0, 32'h10, 32'h0, 2, 0, 32'hFFFF8001, 1, 0);
    run_req("lhu 0x10", 0, 2'b01, 1, 32'h10, 32'h0, 2, 0, 32'h00008001, 1, 0);
    run_req("lh 0x12", 0, 2'b01, 0, 32'h12, 32'h0, 2, 0, 32'h00001122, 1, 0);

    // Errors: no memory access, 1-cycle latency
    run_req("err lw 0x13", 0, 2'b10, 0, 32'h13, 32'h0, 1, 1, 32'h0, 0, 0);
    run_req("err lh 0x11", 0, 2'b01, 0, 32'h11, 32'h0, 1, 1, 32'h0, 0, 0);
    run_req("err size3", 0, 2'b11, 0, 32'h10, 32'h0, 1, 1, 32'h0, 0, 0);
    run_req("err sw 0x400", 1, 2'b10, 0, 32'h400, 32'h5A5A5A5A, 1, 1, 32'h0, 0, 0);
    run_req("sw 0x3FC", 1, 2'b10, 0, 32'h3FC, 32'hCAFEF00D, 2, 0, 32'h0, 0, 1);
    chk("sw 0x3FC addr", last_wr_addr, 32'h3FC);

    // req_valid held high: alternating sw/lw on 0x20
    resp0 = resp_cnt;
    bus.req_valid    = 1'b1;
    bus.req_write    = 1'b1;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h20;
    bus.req_wdata    = 32'hA0000000;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("b2b ready", 32'(bus.req_ready), 32'd1);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 10) begin
        @(negedge clk);
        lat++;
        got = bus.resp_valid;
      end
      chk("b2b latency", 32'(lat), 32'd2);
      chk("b2b rdata", bus.resp_rdata, (i % 2 == 1) ? 32'hA0000000 + 32'(i - 1) : 32'h0);
      if (i == 5) begin
        bus.req_valid = 1'b0;
      end else begin
        bus.req_write = (i % 2 == 1);
        bus.req_wdata = 32'hA0000000 + 32'(i + 1);
      end
      @(negedge clk);
    end
    chk("b2b resp count", 32'(resp_cnt - resp0), 32'd6);

    // Reset during WR of a byte store
    run_req("sw init3", 1, 2'b10, 0, 32'h24, 32'h0, 2, 0, 32'h0, 0, 1);
    bus.req_write = 1'b1;
    bus.req_size  = 2'b00;
    bus.req_addr  = 32'h21;
    bus.req_wdata = 32'h00000055;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 5) begin
      @(negedge clk);
      lat++;
      got = bus.mem_write;
    end
    chk("abort reached WR", 32'(got), 32'd1);
    resp0 = resp_cnt;
    #2;
    reset = 1'b0;
    #1;
    chk("abort mem_write", 32'(bus.mem_write), 32'd0);
    chk("abort ready", 32'(bus.req_ready), 32'd1);
    chk("abort resp_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort no resp", 32'(resp_cnt - resp0), 32'd0);
    run_req("lw after abort", 0, 2'b10, 0, 32'h20, 32'h0, 2, 0, 32'hA0000004, 1, 0);

    chk("enable overlap", 32'(overlap), 32'd0);
    chk("idle bus zero", 32'(bad_idle), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter MEMORY_DEPTH, default 256, SHALL set the number of 32-bit words in the attached data memory; word index = addr[31:2].
REQ-002 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-low reset.
REQ-004 Port req_valid, input, 1: CPU request present.
REQ-005 Port req_ready, output, 1: unit can accept a request this cycle.
REQ-006 Port req_write, input, 1: 1 = store, 0 = load.
REQ-007 Port req_size, input, 2: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 Port req_unsigned, input, 1: loads only; 1 = zero-extend, 0 = sign-extend.
REQ-009 Port req_addr, input, 32: byte address.
REQ-010 Port req_wdata, input, 32: store data, right-justified for byte/halfword.
REQ-011 Port resp_valid, output, 1: one-cycle pulse completing the request.
REQ-012 Port resp_rdata, output, 32: extended load data; 0 for stores and errors.
REQ-013 Port resp_error, output, 1: valid with resp_valid; request was rejected.
REQ-014 Port mem_address, output, 32: byte address to the data memory.
REQ-015 Port mem_write_data, output, 32: full word to write.
REQ-016 Port mem_write, output, 1: memory write enable; memory writes on the rising edge.
REQ-017 Port mem_read, output, 1: memory read enable; mem_read_data is combinational from mem_address and is 0 when mem_read=0.
REQ-018 Port mem_read_data, input, 32: word returned by the memory.

Function
REQ-019 FSM states IDLE, RD, WR, RESP; req_ready=1 only in IDLE; a request is accepted on a rising edge with req_valid=1 in IDLE, and all req_* fields are registered then.
REQ-020 Error conditions: req_size=11; halfword with addr[0]=1; word with addr[1:0]!=00; addr[31:2] >= MEMORY_DEPTH.
REQ-021 Transitions from IDLE on accept: error -> RESP; load -> RD; word store -> WR; byte/halfword store -> RD.
REQ-022 RD: mem_read=1, mem_address = {addr[31:2],2'b00}; the word is captured at the end of the cycle; next state is RESP for a load, WR for a store.
REQ-023 WR: mem_write=1, mem_address = {addr[31:2],2'b00}; next state is RESP.
REQ-024 RESP: resp_valid=1 for exactly one cycle; next state is IDLE.
REQ-025 mem_read and mem_write SHALL never both be 1; both are 0 in IDLE and RESP; mem_address and mem_write_data are 0 outside RD/WR.
REQ-026 Word store: mem_write_data = req_wdata.
REQ-027 Byte store: the captured word with lane addr[1:0] (lane 0 = bits 7:0, little-endian) replaced by wdata[7:0].
REQ-028 Halfword store: lane addr[1] (0 = bits 15:0) replaced by wdata[15:0]; other bits are preserved.
REQ-029 Load: select the byte/halfword lane as for stores, then sign- or zero-extend to 32 bits; a word load returns the word unchanged; req_unsigned is ignored for word loads.
REQ-030 Latency from the accepting edge to resp_valid: error 1 cycle, load 2, word store 2, sub-word store 3.
REQ-031 req_* inputs changing after acceptance SHALL have no effect; back-to-back requests are accepted in the cycle after RESP (IDLE).
REQ-032 An error response SHALL make no memory access.

Reset
REQ-033 On reset low: immediate return to IDLE; all outputs 0 except req_ready=1; registered request and captured data cleared.
REQ-034 Reset asserted during WR SHALL deassert mem_write asynchronously; no resp_valid is produced for the aborted request.

Verification
REQ-035 Store word 0xDEADBEEF to addr 0x10, then load word 0x10 -> one WR cycle writing 0xDEADBEEF to word 4; load resp_rdata=0xDEADBEEF, resp_valid 2 cycles after accept.
REQ-036 With word 4 = 0x11223344: store byte 0xAA at 0x12 -> RD then WR writing 0x11AA3344; lb 0x12 returns 0xFFFFFFAA, lbu 0x12 returns 0x000000AA.
REQ-037 With word 4 = 0x11223344: store half 0x8001 at 0x10 -> writes 0x11228001; lh 0x10 returns 0xFFFF8001, lhu 0x10 returns 0x00008001.
REQ-038 lw 0x13, lh 0x11, size=11, and sw 0x400 (MEMORY_DEPTH=256) -> resp_error=1 one cycle after accept, resp_rdata=0, and mem_read/mem_write stay 0 throughout.
REQ-039 Reset pulsed low mid-WR of a sub-word store -> mem_write falls without waiting for a clock edge, req_ready=1, no resp_valid; a following lw accepted normally.
REQ-040 req_valid held high continuously with alternating sw/lw -> each accepted only in IDLE; exactly one resp_valid per accept; no overlapping memory enables.
